// File: rtl/uart_txfifo_pkg.sv
// Shared constants and read-FSM encoding for the UART transmit FIFO.
package uart_txfifo_pkg;

  localparam int unsigned ByteWidth  = 8;
  localparam int unsigned GuardLimit = 3;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFetch    = 3'd1,
    StLoad     = 3'd2,
    StWaitBusy = 3'd3,
    StWaitDone = 3'd4
  } rd_state_e;

endpackage

// File: rtl/uart_txfifo_if.sv
// Bundle between the system/UART side (master) and the transmit FIFO (slave).
// The ovf signal exists only when UART_TXFIFO_OVF_EN is defined.
interface uart_txfifo_if #(
  parameter int unsigned DEPTHLOG2 = 4
);
  import uart_txfifo_pkg::*;

  logic                 wr;
  logic [ByteWidth-1:0] wdata;
  logic                 full;
  logic                 empty;
  logic [DEPTHLOG2:0]   level;
  logic                 load;
  logic [ByteWidth-1:0] d;
  logic                 txbusy;
`ifdef UART_TXFIFO_OVF_EN
  logic                 ovf;

  modport master (output wr, wdata, txbusy, input full, empty, level, load, d, ovf);
  modport slave  (input wr, wdata, txbusy, output full, empty, level, load, d, ovf);
`else
  modport master (output wr, wdata, txbusy, input full, empty, level, load, d);
  modport slave  (input wr, wdata, txbusy, output full, empty, level, load, d);
`endif

endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port RAM, synchronous write and registered read. No reset on the
// array or read register so the tools can map it to SB_RAM40_4K for deep configs.
module uart_fifo_mem #(
  parameter int unsigned DEPTHLOG2 = 4,
  parameter int unsigned Width     = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [DEPTHLOG2-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic                 re,
  input  logic [DEPTHLOG2-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  logic [Width-1:0] mem [1 << DEPTHLOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/uart_txfifo.sv
// Transmit byte FIFO feeding uart_m, paced on txbusy with a stuck-UART guard.
// Optional sticky overflow flag under UART_TXFIFO_OVF_EN.
module uart_txfifo
  import uart_txfifo_pkg::*;
#(
  parameter int unsigned DEPTHLOG2 = 4
) (
  input logic          clk,
  input logic          rst,
  uart_txfifo_if.slave bus
);

  localparam logic [DEPTHLOG2-1:0] PtrOne    = {{(DEPTHLOG2 - 1){1'b0}}, 1'b1};
  localparam logic [DEPTHLOG2:0]   LvlOne    = {{DEPTHLOG2{1'b0}}, 1'b1};
  localparam logic [DEPTHLOG2:0]   FullLevel = {1'b1, {DEPTHLOG2{1'b0}}};
  localparam logic [1:0]           GuardLast = 2'(GuardLimit - 1);

  logic [DEPTHLOG2-1:0] wptr_q, rptr_q;
  logic [DEPTHLOG2:0]   level_q;
  logic [ByteWidth-1:0] d_q, rdata;
  logic [1:0]           guard_q, guard_d;
  rd_state_e            state_q, state_d;
  logic                 full, empty, wr_ok, pop, load, capture;

  assign full  = (level_q == FullLevel);
  assign empty = (level_q == '0);
  assign wr_ok = bus.wr && !full;
  assign pop   = (state_q == StIdle) && !empty && !bus.txbusy;

  uart_fifo_mem #(
    .DEPTHLOG2 (DEPTHLOG2),
    .Width     (ByteWidth)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr_q),
    .wdata (bus.wdata),
    .re    (pop),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + PtrOne;
      if (pop)   rptr_q <= rptr_q + PtrOne;
      if (wr_ok && !pop) begin
        level_q <= level_q + LvlOne;
      end else if (pop && !wr_ok) begin
        level_q <= level_q - LvlOne;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      guard_q <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      if (capture) d_q <= rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    load    = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) state_d = StFetch;
      end
      StFetch: begin
        capture = 1'b1;
        state_d = StLoad;
      end
      StLoad: begin
        load    = 1'b1;
        guard_d = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.txbusy) begin
          state_d = StWaitDone;
        end else begin
          guard_d = guard_q + 2'd1;
          // Give up on a UART that never raises txbusy.
          if (guard_q == GuardLast) state_d = StIdle;
        end
      end
      StWaitDone: begin
        if (!bus.txbusy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef UART_TXFIFO_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.wr && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.level = level_q;
  assign bus.load  = load;
  assign bus.d     = d_q;

endmodule
